// File: rtl/uncached_wbuf_bridge.sv
// Uncached MEM-stage bridge: posted-store write buffer plus blocking loads onto an SRAM-like bus.
// Define WB_RAW_BYPASS_EN to let loads pass buffered stores to other words.
module uncached_wbuf_bridge #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wb_empty,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [29:0]   q_word [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [3:0]    q_be   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          op_wr;
  logic [29:0]   op_word;
  logic [31:0]   op_wdata;
  logic [3:0]    op_be;

  logic [29:0]   masked_word;
  logic          full;
  logic          empty;
  logic          read_go;
  logic          push;
  logic          pop;
  logic          read_done;
  logic [1:0]    size;
  logic [1:0]    off;
  logic          unused_lo;

  assign masked_word = addr[31:2] & PHYS_MASK[31:2];
  assign unused_lo   = ^addr[1:0];
  assign full        = count == (AW+1)'(DEPTH);
  assign empty       = count == '0;

`ifdef WB_RAW_BYPASS_EN
  logic hit;

  // any live entry on the same word forces the load to wait for the drain
  always_comb begin : hit_scan
    logic [AW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((AW+1)'(i) < count && q_word[idx] == masked_word)
        hit = 1'b1;
    end
  end

  assign read_go = mem_read && !hit;
`else
  assign read_go = mem_read && empty;
`endif

  assign push      = mem_write && !full;
  assign pop       = state == IDLE && !read_go && !empty;
  assign read_done = state == RESP && !op_wr && data_data_ok;

  always_ff @(posedge clk) begin
    if (push) begin
      q_word[wr_ptr] <= masked_word;
      q_data[wr_ptr] <= wdata;
      q_be[wr_ptr]   <= be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      op_wr    <= 1'b0;
      op_word  <= '0;
      op_wdata <= '0;
      op_be    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (!push && pop)
        count <= count - (AW+1)'(1);
      case (state)
        IDLE: begin
          if (read_go) begin
            op_wr    <= 1'b0;
            op_word  <= masked_word;
            op_wdata <= '0;
            op_be    <= be;
            state    <= REQ;
          end else if (!empty) begin
            op_wr    <= 1'b1;
            op_word  <= q_word[rd_ptr];
            op_wdata <= q_data[rd_ptr];
            op_be    <= q_be[rd_ptr];
            state    <= REQ;
          end
        end
        REQ:     if (data_addr_ok) state <= RESP;
        RESP:    if (data_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    size = 2'd2;
    off  = 2'd0;
    case (op_be)
      4'b0001: begin size = 2'd0; off = 2'd0; end
      4'b0010: begin size = 2'd0; off = 2'd1; end
      4'b0100: begin size = 2'd0; off = 2'd2; end
      4'b1000: begin size = 2'd0; off = 2'd3; end
      4'b0011: begin size = 2'd1; off = 2'd0; end
      4'b1100: begin size = 2'd1; off = 2'd2; end
      default: begin size = 2'd2; off = 2'd0; end
    endcase
  end

  assign data_req   = state == REQ;
  assign data_wr    = data_req && op_wr;
  assign data_size  = data_req ? size : 2'd0;
  assign data_addr  = data_req ? {op_word, off} : 32'h0;
  assign data_wdata = data_wr ? op_wdata : 32'h0;

  assign rvalid   = read_done;
  assign rdata    = read_done ? data_rdata : 32'h0;
  assign stall    = (mem_read && !read_done) || (mem_write && full);
  assign wb_empty = empty && !(state != IDLE && op_wr);

endmodule
